// File: rtl/btn_conditioner.sv
// Push-button conditioner: per channel a 2-flop synchroniser, a debounce filter,
// registered press/release pulses and a hold-to-auto-repeat pulse generator.
module btn_conditioner #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 10_000_000,
  parameter int CNT_W           = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_pulse
);

  typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RATE} rp_state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             stable;
    logic             press_q;
    logic             release_q;
    logic             pulse_q;
    logic [CNT_W-1:0] db_cnt;
    logic             db_fire;
    logic             rise;
    logic             fall;
    rp_state_t        rp_state;
    rp_state_t        rp_state_nxt;
    logic [CNT_W-1:0] rp_cnt;
    logic [CNT_W-1:0] rp_cnt_nxt;
    logic             pulse_nxt;

    // rise/fall are the edges at which the new stable level is registered, so the
    // press/release/pulse registers line up with the first cycle of the new level.
    assign db_fire = (s2 != stable) && (db_cnt == DB_LAST);
    assign rise    = db_fire & s2;
    assign fall    = db_fire & ~s2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1        <= 1'b0;
        s2        <= 1'b0;
        stable    <= 1'b0;
        db_cnt    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        s1        <= btn_raw[g];
        s2        <= s1;
        press_q   <= rise;
        release_q <= fall;
        if (s2 == stable) begin
          db_cnt <= '0;
        end else if (db_fire) begin
          stable <= s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rp_state <= R_IDLE;
        rp_cnt   <= '0;
        pulse_q  <= 1'b0;
      end else begin
        rp_state <= rp_state_nxt;
        rp_cnt   <= rp_cnt_nxt;
        pulse_q  <= pulse_nxt;
      end
    end

    // A release wins over any repeat pulse falling due in the same cycle.
    always_comb begin
      rp_state_nxt = rp_state;
      rp_cnt_nxt   = rp_cnt;
      pulse_nxt    = 1'b0;
      if (fall) begin
        rp_state_nxt = R_IDLE;
        rp_cnt_nxt   = '0;
      end else begin
        case (rp_state)
          R_IDLE: begin
            if (rise) begin
              rp_state_nxt = R_DELAY;
              rp_cnt_nxt   = '0;
              pulse_nxt    = 1'b1;
            end
          end
          R_DELAY: begin
            if (REPEAT_EN) begin
              if (rp_cnt == RD_LAST) begin
                rp_state_nxt = R_RATE;
                rp_cnt_nxt   = '0;
                pulse_nxt    = 1'b1;
              end else begin
                rp_cnt_nxt = rp_cnt + 1'b1;
              end
            end
          end
          R_RATE: begin
            if (rp_cnt == RR_LAST) begin
              rp_cnt_nxt = '0;
              pulse_nxt  = 1'b1;
            end else begin
              rp_cnt_nxt = rp_cnt + 1'b1;
            end
          end
          default: begin
            rp_state_nxt = R_IDLE;
            rp_cnt_nxt   = '0;
          end
        endcase
      end
    end

    assign btn_level[g]   = stable;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
    assign btn_pulse[g]   = pulse_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: sample-history debounce model, age-based repeat model,
// per-cycle comparison of two builds (repeat on / off) plus directed timing checks.
module tb_btn_conditioner;
  localparam int N  = 3;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] level, press, rel, pulse;
  logic [N-1:0] level_n, press_n, rel_n, pulse_n;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  btn_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b1),
                    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(level),
    .btn_press(press), .btn_release(rel), .btn_pulse(pulse));

  btn_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b0),
                    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(4)) dut_norep (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(level_n),
    .btn_press(press_n), .btn_release(rel_n), .btn_pulse(pulse_n));

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: hist[0] is the raw value taken at the previous edge. The level flips once
  // the last DB synchronised samples (hist[1..DB]) all disagree with it.
  logic [N-1:0] hist [0:DB];
  logic [N-1:0] m_level, m_press, m_rel;
  int unsigned  cyc;
  int unsigned  press_at [N];

  function automatic logic flips(input int ch);
    for (int k = 1; k <= DB; k++)
      if (hist[k][ch] == m_level[ch]) return 1'b0;
    return 1'b1;
  endfunction

  // Pulse expected at press, at press+RD, then every RR while still held.
  function automatic logic [N-1:0] exp_pulse(input logic rep_en);
    logic [N-1:0] v;
    int unsigned  age;
    v = '0;
    for (int i = 0; i < N; i++) begin
      age = cyc - press_at[i];
      if (m_level[i]) begin
        if (age == 0) v[i] = 1'b1;
        else if (rep_en && age >= RD && ((age - RD) % RR) == 0) v[i] = 1'b1;
      end
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= DB; k++) hist[k] <= '0;
      m_level <= '0;
      m_press <= '0;
      m_rel   <= '0;
      cyc     <= 0;
      for (int i = 0; i < N; i++) press_at[i] <= 0;
    end else begin
      cyc     <= cyc + 1;
      hist[0] <= btn_raw;
      for (int k = 1; k <= DB; k++) hist[k] <= hist[k-1];
      for (int i = 0; i < N; i++) begin
        if (flips(i)) begin
          m_level[i] <= ~m_level[i];
          m_press[i] <= ~m_level[i];
          m_rel[i]   <= m_level[i];
          if (!m_level[i]) press_at[i] <= cyc + 1;
        end else begin
          m_press[i] <= 1'b0;
          m_rel[i]   <= 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("cyc_level", level, m_level);
    check("cyc_press", press, m_press);
    check("cyc_release", rel, m_rel);
    check("cyc_pulse", pulse, exp_pulse(1'b1));
    check("cyc_level_norep", level_n, m_level);
    check("cyc_press_norep", press_n, m_press);
    check("cyc_release_norep", rel_n, m_rel);
    check("cyc_pulse_norep", pulse_n, exp_pulse(1'b0));
  end

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         np, npn, rise_e, rel_off;

  initial begin
    // Reset with all buttons held, then fresh press on all channels.
    rst_n   = 1'b0;
    btn_raw = 3'b111;
    repeat (3) @(negedge clk);
    check("rst_level", level, 3'b000);
    check("rst_press", press, 3'b000);
    check("rst_pulse", pulse, 3'b000);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("t1_level_early", level, 3'b000);
    @(posedge clk);
    #1;
    check("t1_level", level, 3'b111);
    check("t1_press", press, 3'b111);
    check("t1_pulse", pulse, 3'b111);
    check("t1_pulse_norep", pulse_n, 3'b111);
    @(posedge clk);
    #1;
    check("t1_press_once", press, 3'b000);
    check("t1_pulse_once", pulse, 3'b000);
    @(negedge clk) btn_raw = 3'b000;
    repeat (12) @(negedge clk);

    // A 3-cycle glitch is rejected.
    btn_raw[0] = 1'b1;
    repeat (3) @(negedge clk);
    btn_raw[0] = 1'b0;
    np = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1 if (press[0]) np++;
    end
    check_int("t2_glitch_press", np, 0);

    // Bounce 1,0,1,0 then steady 1: one press, level up 6 edges into the steady run.
    for (int b = 0; b < 4; b++) begin
      @(negedge clk) btn_raw[0] = ~b[0];
    end
    @(negedge clk) btn_raw[0] = 1'b1;
    np = 0;
    rise_e = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      if (press[0]) np++;
      if (level[0] && rise_e == 0) rise_e = e;
    end
    check_int("t2_rise_edge", rise_e, 6);
    check_int("t2_press_cnt", np, 1);
    @(negedge clk) btn_raw[0] = 1'b0;
    repeat (12) @(negedge clk);

    // Hold channel 1: pulses at 0, 10, 13, ... until the debounced release at offset 45.
    btn_raw[1] = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("t3_press", press, 3'b010);
    exp_q = '{8'd0, 8'd10, 8'd13, 8'd16, 8'd19, 8'd22, 8'd25, 8'd28, 8'd31,
              8'd34, 8'd37, 8'd40, 8'd43};
    got_q = {};
    np = 0;
    rel_off = -1;
    for (int off = 0; off < 60; off++) begin
      if (pulse[1]) got_q.push_back(8'(off));
      if (press[1]) np++;
      if (rel[1]) rel_off = off;
      if (off == 39) @(negedge clk) btn_raw[1] = 1'b0;
      @(posedge clk);
      #1;
    end
    check_int("t3_pulse_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_int("t3_pulse_offset", int'(got_q[i]), int'(exp_q[i]));
    check_int("t3_press_cnt", np, 1);
    check_int("t3_release_off", rel_off, 45);

    // Release lands on a due repeat (offset 16): release wins, no pulse.
    @(negedge clk) btn_raw[1] = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("t4_press", press, 3'b010);
    for (int off = 0; off < 16; off++) begin
      if (off == 10) @(negedge clk) btn_raw[1] = 1'b0;
      @(posedge clk);
      #1;
    end
    check("t4_release", rel, 3'b010);
    check("t4_no_pulse", pulse, 3'b000);
    repeat (10) @(negedge clk);
    btn_raw[1] = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("t4_repress_pulse", pulse, 3'b010);
    repeat (10) @(posedge clk);
    #1 check("t4_first_repeat", pulse, 3'b010);
    @(negedge clk) btn_raw[1] = 1'b0;
    repeat (12) @(negedge clk);

    // Two channels together, then channel 1 alone; repeat-off build pulses once.
    btn_raw = 3'b101;
    repeat (6) @(posedge clk);
    #1;
    check("t5_press", press, 3'b101);
    check("t5_pulse", pulse, 3'b101);
    check("t5_pulse_norep", pulse_n, 3'b101);
    np = 0;
    npn = 0;
    for (int off = 1; off <= 25; off++) begin
      @(posedge clk);
      #1;
      if (pulse[0]) np++;
      if (pulse_n[0]) npn++;
    end
    check_int("t5_repeat_cnt", np, 6);
    check_int("t5_norep_cnt", npn, 0);
    @(negedge clk) btn_raw[1] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t5_press_ch1", press, 3'b010);
    check("t5_level_all", level, 3'b111);

    // Asynchronous reset while channels 0/2 are in the repeat-rate phase.
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_level", level, 3'b000);
    check("t6_press", press, 3'b000);
    check("t6_release", rel, 3'b000);
    check("t6_pulse", pulse, 3'b000);
    check("t6_pulse_norep", pulse_n, 3'b000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t6_fresh_press", press, 3'b111);
    check("t6_fresh_pulse", pulse, 3'b111);
    @(negedge clk) btn_raw = 3'b000;
    repeat (15) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
